// File: rtl/fft4_pkg.sv
// Shared widths, scaling and state encoding for the 4-point FFT frame engine.
package fft4_pkg;

  localparam int DATA_W_DFLT = 16;
  localparam int STG1_W      = DATA_W_DFLT + 1;
  localparam int STG2_W      = DATA_W_DFLT + 2;
  localparam int SCALE_SHIFT = 2;
  localparam int FRAME_LEN   = 4;

  typedef enum logic [1:0] {
    COLLECT,
    STAGE1,
    STAGE2
  } state_t;

endpackage

// File: rtl/fft4_frame_engine_if.sv
// Sample-in handshake and parallel bin-out bus of the FFT frame engine.
interface fft4_frame_engine_if
  import fft4_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int FCNT_W = 8
);

  logic                     in_valid;
  logic                     in_ready;
  logic                     in_sync;
  logic signed [DATA_W-1:0] in_real;
  logic signed [DATA_W-1:0] in_imag;

  logic signed [DATA_W-1:0] X0_real;
  logic signed [DATA_W-1:0] X0_imag;
  logic signed [DATA_W-1:0] X1_real;
  logic signed [DATA_W-1:0] X1_imag;
  logic signed [DATA_W-1:0] X2_real;
  logic signed [DATA_W-1:0] X2_imag;
  logic signed [DATA_W-1:0] X3_real;
  logic signed [DATA_W-1:0] X3_imag;
  logic                     out_valid;
  logic [FCNT_W-1:0]        frame_cnt;

  // The engine drives the bins; the environment sources samples and consumes bins.
  modport master (
    input  in_valid, in_sync, in_real, in_imag,
    output in_ready,
    output X0_real, X0_imag, X1_real, X1_imag,
    output X2_real, X2_imag, X3_real, X3_imag,
    output out_valid, frame_cnt
  );

  modport slave (
    output in_valid, in_sync, in_real, in_imag,
    input  in_ready,
    input  X0_real, X0_imag, X1_real, X1_imag,
    input  X2_real, X2_imag, X3_real, X3_imag,
    input  out_valid, frame_cnt
  );

endinterface

// File: rtl/fft4_butterfly.sv
// Combinational signed radix-2 pair: full-precision sum and difference.
module fft4_butterfly #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W:0]   sum,
  output logic signed [W:0]   diff
);

  always_comb begin
    sum  = (W+1)'(a) + (W+1)'(b);
    diff = (W+1)'(a) - (W+1)'(b);
  end

endmodule

// File: rtl/fft4_frame_engine.sv
// Four-point radix-2 DIT FFT: serial sample collection, two registered
// butterfly stages, parallel bin outputs scaled by 1/4.
module fft4_frame_engine
  import fft4_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int FCNT_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  fft4_frame_engine_if.master bus
);

  localparam int S1W = DATA_W + (STG1_W - DATA_W_DFLT);
  localparam int S2W = DATA_W + (STG2_W - DATA_W_DFLT);

  state_t                   state;
  logic [1:0]               idx;
  logic signed [DATA_W-1:0] smp_r [FRAME_LEN];
  logic signed [DATA_W-1:0] smp_i [FRAME_LEN];

  logic signed [S1W-1:0] a_r, a_i, b_r, b_i, c_r, c_i, d_r, d_i;
  logic signed [S1W-1:0] s1_a_r, s1_a_i, s1_b_r, s1_b_i;
  logic signed [S1W-1:0] s1_c_r, s1_c_i, s1_d_r, s1_d_i;
  logic signed [S2W-1:0] y0_r, y0_i, y1_r, y1_i, y2_r, y2_i, y3_r, y3_i;
  logic                  scale_unused;
  logic                  take;

  assign bus.in_ready = (state == COLLECT) && !rst;
  assign take         = bus.in_valid && bus.in_ready;

  // Stage 1: pairs (x0,x2) and (x1,x3).
  fft4_butterfly #(.W(DATA_W)) u_bf_02_r (.a(smp_r[0]), .b(smp_r[2]), .sum(s1_a_r), .diff(s1_b_r));
  fft4_butterfly #(.W(DATA_W)) u_bf_02_i (.a(smp_i[0]), .b(smp_i[2]), .sum(s1_a_i), .diff(s1_b_i));
  fft4_butterfly #(.W(DATA_W)) u_bf_13_r (.a(smp_r[1]), .b(smp_r[3]), .sum(s1_c_r), .diff(s1_d_r));
  fft4_butterfly #(.W(DATA_W)) u_bf_13_i (.a(smp_i[1]), .b(smp_i[3]), .sum(s1_c_i), .diff(s1_d_i));

  // Stage 2: the -j twiddle on d is folded in by crossing d's real/imag parts.
  fft4_butterfly #(.W(S1W)) u_bf_x02_r (.a(a_r), .b(c_r), .sum(y0_r), .diff(y2_r));
  fft4_butterfly #(.W(S1W)) u_bf_x02_i (.a(a_i), .b(c_i), .sum(y0_i), .diff(y2_i));
  fft4_butterfly #(.W(S1W)) u_bf_x13_r (.a(b_r), .b(d_i), .sum(y1_r), .diff(y3_r));
  fft4_butterfly #(.W(S1W)) u_bf_x13_i (.a(b_i), .b(d_r), .sum(y3_i), .diff(y1_i));

  // Fraction bits dropped by the floor scaling.
  assign scale_unused = ^{y0_r[SCALE_SHIFT-1:0], y0_i[SCALE_SHIFT-1:0],
                          y1_r[SCALE_SHIFT-1:0], y1_i[SCALE_SHIFT-1:0],
                          y2_r[SCALE_SHIFT-1:0], y2_i[SCALE_SHIFT-1:0],
                          y3_r[SCALE_SHIFT-1:0], y3_i[SCALE_SHIFT-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COLLECT;
      idx   <= '0;
      for (int unsigned k = 0; k < FRAME_LEN; k++) begin
        smp_r[k] <= '0;
        smp_i[k] <= '0;
      end
      {a_r, a_i, b_r, b_i, c_r, c_i, d_r, d_i} <= '0;
      bus.X0_real   <= '0;
      bus.X0_imag   <= '0;
      bus.X1_real   <= '0;
      bus.X1_imag   <= '0;
      bus.X2_real   <= '0;
      bus.X2_imag   <= '0;
      bus.X3_real   <= '0;
      bus.X3_imag   <= '0;
      bus.out_valid <= 1'b0;
      bus.frame_cnt <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      case (state)
        COLLECT: begin
          if (take) begin
            if (bus.in_sync) begin
              smp_r[0] <= bus.in_real;
              smp_i[0] <= bus.in_imag;
              idx      <= 2'd1;
            end else begin
              smp_r[idx] <= bus.in_real;
              smp_i[idx] <= bus.in_imag;
              idx        <= idx + 2'd1;
              if (idx == 2'(FRAME_LEN - 1)) state <= STAGE1;
            end
          end
        end
        STAGE1: begin
          a_r   <= s1_a_r;
          a_i   <= s1_a_i;
          b_r   <= s1_b_r;
          b_i   <= s1_b_i;
          c_r   <= s1_c_r;
          c_i   <= s1_c_i;
          d_r   <= s1_d_r;
          d_i   <= s1_d_i;
          state <= STAGE2;
        end
        STAGE2: begin
          bus.X0_real   <= y0_r[SCALE_SHIFT +: DATA_W];
          bus.X0_imag   <= y0_i[SCALE_SHIFT +: DATA_W];
          bus.X1_real   <= y1_r[SCALE_SHIFT +: DATA_W];
          bus.X1_imag   <= y1_i[SCALE_SHIFT +: DATA_W];
          bus.X2_real   <= y2_r[SCALE_SHIFT +: DATA_W];
          bus.X2_imag   <= y2_i[SCALE_SHIFT +: DATA_W];
          bus.X3_real   <= y3_r[SCALE_SHIFT +: DATA_W];
          bus.X3_imag   <= y3_i[SCALE_SHIFT +: DATA_W];
          bus.out_valid <= 1'b1;
          bus.frame_cnt <= bus.frame_cnt + FCNT_W'(1);
          state         <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_fft4_frame_engine.sv
// Self-checking bench for fft4_frame_engine: directed and random frames
// compared against a direct 4-point DFT computed in the bench.
module tb_fft4_frame_engine;

  localparam int DW = 16;
  localparam int FW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fft4_frame_engine_if #(.DATA_W(DW), .FCNT_W(FW)) bus ();

  fft4_frame_engine #(.DATA_W(DW), .FCNT_W(FW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int pulses = 0;
  int hold_err = 0;
  int exp_pulses = 0;
  int exp_fc = 0;
  int acc_cyc = 0;
  int stall = 0;

  int fr[4], fi[4], er[4], ei[4];

  logic [127:0] now_bins;
  logic [127:0] last_bins;
  logic [127:0] bins_q[$];
  int           fc_q[$];
  int           cyc_q[$];

  assign now_bins = {bus.X0_real, bus.X0_imag, bus.X1_real, bus.X1_imag,
                     bus.X2_real, bus.X2_imag, bus.X3_real, bus.X3_imag};

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every out_valid pulse; between pulses the bins must not move.
  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1) begin
      bins_q.push_back(now_bins);
      fc_q.push_back(int'(bus.frame_cnt));
      cyc_q.push_back(cyc);
      pulses <= pulses + 1;
    end else if (!rst && now_bins !== last_bins) begin
      hold_err <= hold_err + 1;
    end
    last_bins <= now_bins;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d required %0d", tag, obs, exp);
  endtask

  function automatic int comp(input logic [127:0] v, input int k);
    logic signed [15:0] s;
    s = v[127-16*k -: 16];
    return int'(s);
  endfunction

  // X[k] = sum x[n] * (-j)^(n*k), then floor-divide by 4.
  function automatic void dft4();
    for (int k = 0; k < 4; k++) begin
      int sr;
      int si;
      sr = 0;
      si = 0;
      for (int n = 0; n < 4; n++) begin
        case ((n * k) % 4)
          0:       begin sr += fr[n]; si += fi[n]; end
          1:       begin sr += fi[n]; si -= fr[n]; end
          2:       begin sr -= fr[n]; si -= fi[n]; end
          default: begin sr -= fi[n]; si += fr[n]; end
        endcase
      end
      er[k] = sr >>> 2;
      ei[k] = si >>> 2;
    end
  endfunction

  task automatic send(input int r, input int im, input bit sync);
    int st;
    st = 0;
    bus.in_valid = 1'b1;
    bus.in_sync  = sync;
    bus.in_real  = DW'(r);
    bus.in_imag  = DW'(im);
    while (bus.in_ready !== 1'b1 && st < 20) begin
      @(negedge clk); #1;
      st++;
    end
    if (st >= 20) chk("ready_timeout", st, 0);
    @(negedge clk); #1;
    acc_cyc = cyc;
    stall   = st;
  endtask

  task automatic send_frame(input int gapmax);
    for (int n = 0; n < 4; n++) begin
      send(fr[n], fi[n], n == 0);
      if (n < 3 && gapmax > 0) begin
        int g;
        g = int'($urandom_range(0, gapmax));
        if (g > 0) begin
          bus.in_valid = 1'b0;
          repeat (g) begin @(negedge clk); #1; end
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;
  endtask

  task automatic check_frame(input bit lat);
    int g;
    logic [127:0] b;
    int fc;
    int oc;
    g = 0;
    dft4();
    exp_pulses++;
    exp_fc = (exp_fc + 1) % (1 << FW);
    while (bins_q.size() == 0 && g < 20) begin
      @(negedge clk); #1;
      g++;
    end
    if (bins_q.size() == 0) begin
      chk("out_valid_timeout", g, 0);
      return;
    end
    b  = bins_q.pop_front();
    fc = fc_q.pop_front();
    oc = cyc_q.pop_front();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("X%0d_real", k), comp(b, 2*k), er[k]);
      chk($sformatf("X%0d_imag", k), comp(b, 2*k+1), ei[k]);
    end
    chk("frame_cnt", fc, exp_fc);
    if (lat) chk("latency", oc - acc_cyc, 2);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;
    bus.in_real  = '0;
    bus.in_imag  = '0;

    #12;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_X0_real", bus.X0_real, 0);
    chk("rst_X3_imag", bus.X3_imag, 0);
    chk("rst_frame_cnt", bus.frame_cnt, 0);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("ready_after_rst", bus.in_ready, 1);

    fr = '{1024, 0, 0, 0};       fi = '{0, 0, 0, 0};
    send_frame(0); check_frame(1);
    fr = '{400, 400, 400, 400};  fi = '{0, 0, 0, 0};
    send_frame(0); check_frame(1);
    fr = '{800, -800, 800, -800}; fi = '{0, 0, 0, 0};
    send_frame(0); check_frame(1);
    fr = '{1000, 0, -1000, 0};   fi = '{0, 1000, 0, -1000};
    send_frame(0); check_frame(1);

    // Full scale with in_valid held high across three frames.
    fr = '{-32768, -32768, -32768, -32768};
    fi = '{-32768, -32768, -32768, -32768};
    for (int s = 0; s < 12; s++) begin
      send(-32768, -32768, (s % 4) == 0);
      chk($sformatf("stall_s%0d", s), stall, ((s % 4) == 0 && s > 0) ? 2 : 0);
    end
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;
    check_frame(0);
    check_frame(0);
    check_frame(0);

    // Realign: a two-sample partial frame is discarded by in_sync.
    send(111, 222, 1'b1);
    send(333, 444, 1'b0);
    fr = '{1024, 0, 0, 0};       fi = '{0, 0, 0, 0};
    send_frame(0); check_frame(1);
    repeat (8) begin @(negedge clk); #1; end
    chk("realign_pulses", pulses, exp_pulses);

    // Reset during STAGE1 kills the in-flight frame.
    fr = '{5000, -7000, 1234, 99}; fi = '{-3, 4000, -22000, 17};
    send_frame(0);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_X0_real", bus.X0_real, 0);
    chk("midrst_X1_imag", bus.X1_imag, 0);
    chk("midrst_frame_cnt", bus.frame_cnt, 0);
    repeat (3) begin @(negedge clk); #1; end
    rst = 1'b0;
    exp_fc = 0;
    repeat (6) begin @(negedge clk); #1; end
    chk("midrst_no_pulse", pulses, exp_pulses);
    fr = '{400, 400, 400, 400};  fi = '{0, 0, 0, 0};
    send_frame(0); check_frame(1);

    // Random frames with idle gaps; long enough to wrap frame_cnt.
    for (int f = 0; f < 260; f++) begin
      for (int n = 0; n < 4; n++) begin
        logic signed [15:0] tr;
        logic signed [15:0] ti;
        tr = 16'($urandom);
        ti = 16'($urandom);
        fr[n] = tr;
        fi[n] = ti;
      end
      send_frame(2);
      check_frame(1);
    end

    repeat (8) begin @(negedge clk); #1; end
    chk("total_pulses", pulses, exp_pulses);
    chk("hold_violations", hold_err, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fft4_frame_engine.md
Name: fft4_frame_engine

Overview:
Four-point radix-2 DIT FFT producer. It accepts complex time-domain samples serially over a valid/ready handshake and buffers each frame of 4 samples. It then computes the 4 frequency bins in two registered butterfly stages and presents them in parallel as X0..X3 real/imag.
This is the driving end of the bin interface that the downstream magnitude stage consumes every clock. It pulses out_valid once per new frame.

Parameters:
DATA_W, 16, signed sample width of inputs and of every output bin component.
FCNT_W, 8, width of the frame counter.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_real/in_imag/in_sync carry a sample this cycle
in_ready  output  1  engine can accept a sample this cycle
in_sync  input  1  qualified by in_valid; marks this sample as sample 0 of a frame
in_real  input  DATA_W  signed sample real part
in_imag  input  DATA_W  signed sample imaginary part
X0_real, X0_imag, X1_real, X1_imag, X2_real, X2_imag, X3_real, X3_imag  output  DATA_W each  signed bins, registered, held until next frame
out_valid  output  1  one-cycle pulse: new bins are present this cycle
frame_cnt  output  FCNT_W  count of frames emitted

Behaviour:
- Reset (async, rst=1): state=COLLECT, sample index=0. All X* outputs=0, out_valid=0, frame_cnt=0. in_ready=0 while rst is high, then 1 in COLLECT.
- Handshake: a sample transfers on a rising edge where in_valid && in_ready. in_ready=1 only in COLLECT; the source holds data while in_ready=0.
- COLLECT: each transfer writes buffer[idx] and increments idx.
  - Transfer with in_sync=1: sample goes to buffer[0], idx=1, and any partial frame is discarded.
  - Transfer at idx=3: goto STAGE1, idx wraps to 0.
- STAGE1 (1 cycle, in_ready=0): register a=x0+x2, b=x0-x2, c=x1+x3, d=x1-x3 per component, DATA_W+1 bits each. Goto STAGE2.
- STAGE2 (1 cycle, in_ready=0): compute the DATA_W+2-bit sums:
  - X0=a+c
  - X2=a-c
  - X1_real=b_r+d_i, X1_imag=b_i-d_r
  - X3_real=b_r-d_i, X3_imag=b_i+d_r
- Output scaling: each result is arithmetic-shifted right by 2 (floor) into DATA_W bits. Full-scale inputs cannot overflow, so no saturation is needed.
- Output update: on the STAGE2 exit edge, load all 8 outputs, set out_valid=1 for the following cycle only, increment frame_cnt (wraps 2^FCNT_W-1 -> 0), goto COLLECT.
- Latency: out_valid is high in the cycle starting 2 edges after the edge that accepted sample 3. Peak throughput is one frame per 6 cycles.
- Hold: outputs do not change between out_valid pulses.
- Mid-operation events:
  - in_sync or in_valid during STAGE1/STAGE2 is ignored because in_ready=0.
  - rst asserted in any state clears immediately; any partial frame or in-flight computation is lost and out_valid is not pulsed.

Decomposition:
- Package fft4_pkg:
  - DATA_W default
  - stage widths STG1_W=DATA_W+1, STG2_W=DATA_W+2
  - SCALE_SHIFT=2
  - state enum {COLLECT, STAGE1, STAGE2}
- Sub-module fft4_butterfly: combinational signed radix-2 pair (sum, difference) with width parameter. Instantiated for the stage-1 and stage-2 add/sub pairs.

Test Plan:
1. Impulse: x0=(1024,0), x1..x3=0 -> all bins real=256, imag=0; out_valid one cycle; frame_cnt=1.
2. DC: all four samples (400,0) -> X0=(400,0); X1, X2, X3=(0,0).
3. Nyquist and quarter tone:
   - (800,0),(-800,0),(800,0),(-800,0) -> X2=(800,0), others 0.
   - (1000,0),(0,1000),(-1000,0),(0,-1000) -> X1=(1000,0), others 0.
4. Full scale: all samples (-32768,-32768) -> X0=(-32768,-32768), others 0, no overflow. Hold in_valid=1 continuously -> in_ready low exactly 2 cycles per frame, no sample lost or duplicated; 3 back-to-back frames give frame_cnt=3.
5. Realign: send 2 samples, then in_sync with impulse (1024,0) plus 3 zeros -> single out_valid, bins all (256,0); partial frame dropped.
6. Reset mid-frame: assert rst during STAGE1 -> outputs 0, out_valid never pulses, frame_cnt=0. After release, a DC frame of (400,0) gives X0=(400,0).
